sobel_stream: RTL and testbench
===============================

# sobel_stream

Streaming, parametrised successor to the whole-frame edge detector. It accepts raster-order pixels over a valid/ready handshake and forms 3x3 windows from two internal line buffers. For each pixel it emits the Sobel gradient magnitude plus a thresholded edge bit, in raster order. It replaces the array-in/array-out gradient stage and feeds downstream suppression/hysteresis stages without frame-sized storage.

## Interface
- IMG_W, 50, pixels per line (≥3)
- IMG_H, 50, lines per frame (≥3)
- PIX_W, 8, bits per pixel, input and output magnitude
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid & s_ready
- s_data  in  PIX_W  input pixel, unsigned
- s_sof  in  1  marks the first pixel of a frame
- cfg_thresh  in  PIX_W  edge threshold, sampled when an s_sof pixel is accepted
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  PIX_W  saturated gradient magnitude
- m_edge  out  1  m_data ≥ sampled threshold
- m_sof  out  1  first output pixel of a frame
- m_eof  out  1  last output pixel of a frame (index N-1, N = IMG_W*IMG_H)
- frame_done  out  1  one-cycle pulse after the m_eof handshake
- err_sof  out  1  one-cycle pulse on s_sof accepted mid-frame

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - s_ready=1; accepted pixels without s_sof are discarded silently.
  - An accepted s_sof pixel becomes input index 0, latches cfg_thresh, and moves the block to RUN.
- RUN:
  - Each accepted pixel j is written to the line buffers and window registers.
  - Once j ≥ IMG_W+1, output index k = j-IMG_W-1 is produced (center pixel row r=k/IMG_W, column c=k%IMG_W).
  - After input index N-1 is accepted, go to FLUSH.
- FLUSH:
  - s_ready=0.
  - The remaining IMG_W+1 outputs (indices N-IMG_W-1..N-1) are generated internally, one per output slot.
  - After the m_eof handshake, pulse frame_done and return to IDLE.
- Border outputs (r=0, r=IMG_H-1, c=0, c=IMG_W-1): m_data=0, m_edge=0, regardless of input.
- Interior arithmetic:
  - Gx = (p[r-1][c+1]+2p[r][c+1]+p[r+1][c+1]) − (p[r-1][c-1]+2p[r][c-1]+p[r+1][c-1]); Gy is the same with rows and columns swapped (bottom minus top).
  - Gx and Gy are signed, PIX_W+3 bits.
  - mag = |Gx|+|Gy| (unsigned, PIX_W+4 bits), saturated to 2^PIX_W−1 for m_data.
  - m_edge is computed on the saturated value.
- Mid-frame s_sof (accepted with in-frame index ≠0, in RUN):
  - err_sof pulses.
  - The old frame is abandoned; any output already registered still completes its handshake, and no further old-frame outputs are produced.
  - The pixel becomes index 0 of a new frame and cfg_thresh is re-latched.
- cfg_thresh changes outside an s_sof acceptance have no effect on the current frame.
- Reset:
  - State IDLE; counters 0; m_valid, m_data, m_edge, m_sof, m_eof, frame_done and err_sof all 0.
  - s_ready=0 while reset_n is low.
  - Line buffer contents are don't-care; every buffer location is rewritten before it is used.

## Timing
- Output register is single-stage: m_valid rises on the cycle after the producing input handshake (RUN) or the producing internal step (FLUSH).
- Backpressure:
  - s_ready = reset_n & (state≠FLUSH) & (!m_valid | m_ready).
  - While m_valid & !m_ready, the values of m_data, m_edge, m_sof and m_eof hold stable.
- FLUSH throughput: one output per cycle while m_ready=1; IMG_W+1 cycles minimum.
- Frame latency: first output m_valid one cycle after input index IMG_W+1 is accepted.
- frame_done asserts on the cycle after the m_eof handshake; s_ready is 1 on that cycle (IDLE).
- Back-to-back frames: a new s_sof pixel may be accepted on the cycle frame_done is high.
- Reset asserted mid-frame or in FLUSH takes effect immediately: outputs clear with no completion, and the next frame requires s_sof.

## Test plan
- Uniform frame (IMG_W=IMG_H=5, all pixels 100, m_ready=1) -> 25 outputs, all m_data=0 and m_edge=0; m_sof on output 0, m_eof on output 24; one frame_done pulse.
- Vertical step on 5x5 (columns 0–2 = 0, columns 3–4 = 10, cfg_thresh=30):
  - Rows 1–3, columns 2 and 3 -> m_data=40, m_edge=1.
  - Column 1 and all border pixels -> 0.
- Saturation: same step with high side 200 -> interior step pixels give m_data=255 (raw 800).
- Backpressure: random 50% m_ready and random s_valid gaps -> output stream bit-identical to the no-stall run; m_data is stable while stalled; s_ready=0 for the entire FLUSH.
- Mid-frame s_sof on input index 7, followed by a full clean frame:
  - err_sof pulses exactly once.
  - The clean frame yields the correct 25 outputs, with m_sof on its first output.
  - Exactly one frame_done is produced, after that frame.
- Reset in FLUSH, then a 5x5 frame with cfg_thresh changed mid-frame:
  - All outputs clear immediately on reset.
  - The following frame is correct using the threshold latched at its s_sof.

Source files
------------

// File: rtl/sobel_stream.sv
// ============================================================================
// Module   : sobel_stream
// Purpose  : Streaming 3x3 Sobel gradient-magnitude stage. Raster-order pixels
//            arrive over valid/ready, two line buffers plus a two-column
//            window form each 3x3 neighbourhood, and one saturated magnitude
//            plus a thresholded edge bit leaves per input pixel, in raster
//            order. The final IMG_W+1 outputs (all on the border) are
//            generated internally once the last input pixel is accepted.
// Ports    : clk, reset_n            - clock, asynchronous active-low reset
//            s_valid/s_ready/s_data  - input pixel handshake and data
//            s_sof                   - first input pixel of a frame
//            cfg_thresh              - edge threshold, latched with s_sof
//            m_valid/m_ready/m_data  - output magnitude handshake and data
//            m_edge                  - m_data >= latched threshold
//            m_sof/m_eof             - first / last output pixel of a frame
//            frame_done              - pulse after the m_eof handshake
//            err_sof                 - pulse on s_sof accepted mid-frame
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sobel_stream #(
    parameter int IMG_W = 50,
    parameter int IMG_H = 50,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic [PIX_W-1:0] cfg_thresh,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_edge,
    output logic             m_sof,
    output logic             m_eof,
    output logic             frame_done,
    output logic             err_sof
);

    localparam int c_CW = $clog2(IMG_W);
    localparam int c_RW = $clog2(IMG_H);
    localparam int c_FW = $clog2(IMG_W + 2);
    localparam int c_SW = PIX_W + 2;   // a + 2b + c
    localparam int c_GW = PIX_W + 3;   // signed gradient
    localparam int c_MW = PIX_W + 4;   // |Gx| + |Gy|

    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(IMG_H - 1);
    localparam logic [c_FW-1:0] c_FLUSH_N  = c_FW'(IMG_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CW-1:0]    r_col;        // column of the next input pixel
    logic [c_RW-1:0]    r_row;        // row of the next input pixel
    logic [c_FW-1:0]    r_flush_cnt;
    logic [PIX_W-1:0]   r_thresh;

    // r_lb0 holds the previous row, r_lb1 the row before that.
    logic [PIX_W-1:0]   r_lb0 [0:IMG_W-1];
    logic [PIX_W-1:0]   r_lb1 [0:IMG_W-1];
    // Window columns: index 0 = left (c-1), index 1 = centre (c).
    // The right column is the incoming pixel and its two line-buffer reads.
    logic [PIX_W-1:0]   r_top [0:1];
    logic [PIX_W-1:0]   r_mid [0:1];
    logic [PIX_W-1:0]   r_bot [0:1];

    logic               w_slot;
    logic               w_acc;
    logic               w_take;
    logic [c_CW-1:0]    w_wr_col;
    logic [PIX_W-1:0]   w_rt;
    logic [PIX_W-1:0]   w_rm;
    logic               w_emit;
    logic               w_interior;
    logic signed [c_GW-1:0] w_gx;
    logic signed [c_GW-1:0] w_gy;
    logic [c_GW-1:0]    w_ax;
    logic [c_GW-1:0]    w_ay;
    logic [c_MW-1:0]    w_mag;
    logic [PIX_W-1:0]   w_sat;

    function automatic logic [c_SW-1:0] tri_sum(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b,
                                                 input logic [PIX_W-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    assign w_slot  = !m_valid || m_ready;
    assign s_ready = reset_n && (r_state != ST_FLUSH) && w_slot;
    assign w_acc   = s_valid && s_ready;
    // In IDLE only an s_sof pixel is kept; everything else is dropped.
    assign w_take  = w_acc && ((r_state == ST_RUN) || s_sof);
    // A frame-start pixel always lands in column 0, even when it aborts a frame.
    assign w_wr_col = s_sof ? '0 : r_col;
    assign w_rt     = r_lb1[w_wr_col];
    assign w_rm     = r_lb0[w_wr_col];

    // Input (row, col) produces the output centred at (row-1, col-1); for
    // col 0 the centre wraps to the previous row's last column (a border).
    assign w_emit     = (r_row >= c_RW'(2)) || ((r_row == c_RW'(1)) && (r_col != '0));
    assign w_interior = (r_row >= c_RW'(2)) && (r_col >= c_CW'(2));

    assign w_gx = $signed({1'b0, tri_sum(w_rt, w_rm, s_data)})
                - $signed({1'b0, tri_sum(r_top[0], r_mid[0], r_bot[0])});
    assign w_gy = $signed({1'b0, tri_sum(r_bot[0], r_bot[1], s_data)})
                - $signed({1'b0, tri_sum(r_top[0], r_top[1], w_rt)});
    assign w_ax  = w_gx[c_GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    assign w_ay  = w_gy[c_GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    assign w_mag = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_sat = (|w_mag[c_MW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];

    // Line buffers and window carry no reset: every location is written
    // before any interior output reads it.
    always_ff @(posedge clk) begin : p_store
        if (w_take) begin
            r_lb1[w_wr_col] <= w_rm;
            r_lb0[w_wr_col] <= s_data;
            r_top[0] <= r_top[1];
            r_top[1] <= w_rt;
            r_mid[0] <= r_mid[1];
            r_mid[1] <= w_rm;
            r_bot[0] <= r_bot[1];
            r_bot[1] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin : p_ctrl
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_flush_cnt <= '0;
            r_thresh    <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_edge      <= 1'b0;
            m_sof       <= 1'b0;
            m_eof       <= 1'b0;
            frame_done  <= 1'b0;
            err_sof     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_acc && s_sof) begin
                        r_state  <= ST_RUN;
                        r_thresh <= cfg_thresh;
                        r_col    <= c_CW'(1);
                        r_row    <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_acc) begin
                        if (s_sof) begin
                            // Abandon the current frame; any registered output
                            // still drains through the normal handshake.
                            err_sof  <= 1'b1;
                            r_thresh <= cfg_thresh;
                            r_col    <= c_CW'(1);
                            r_row    <= '0;
                        end else begin
                            if (w_emit) begin
                                m_valid <= 1'b1;
                                m_data  <= w_interior ? w_sat : '0;
                                m_edge  <= w_interior && (w_sat >= r_thresh);
                                m_sof   <= (r_row == c_RW'(1)) && (r_col == c_CW'(1));
                                m_eof   <= 1'b0;
                            end
                            if (r_col == c_LAST_COL) begin
                                r_col <= '0;
                                if (r_row == c_LAST_ROW) begin
                                    r_state     <= ST_FLUSH;
                                    r_flush_cnt <= c_FLUSH_N;
                                end else begin
                                    r_row <= r_row + c_RW'(1);
                                end
                            end else begin
                                r_col <= r_col + c_CW'(1);
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Every flushed position lies on the border, so data is 0.
                    if (w_slot && (r_flush_cnt != '0)) begin
                        m_valid     <= 1'b1;
                        m_data      <= '0;
                        m_edge      <= 1'b0;
                        m_sof       <= 1'b0;
                        m_eof       <= (r_flush_cnt == c_FW'(1));
                        r_flush_cnt <= r_flush_cnt - c_FW'(1);
                    end else if (m_valid && m_ready && m_eof) begin
                        r_state    <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_stream.sv
// ============================================================================
// Module   : tb_sobel_stream
// Purpose  : Self-checking bench for sobel_stream on a 5x5 frame. Each frame
//            image is run through a direct Sobel reference to build the
//            expected output stream, which is compared at every output
//            handshake; handshake, flush, stall and reset behaviour is
//            checked alongside.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_stream;

    localparam int W = 5;
    localparam int H = 5;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_sof = 1'b0;
    logic [7:0] cfg_thresh = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_edge;
    logic       m_sof;
    logic       m_eof;
    logic       frame_done;
    logic       err_sof;

    sobel_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .cfg_thresh (cfg_thresh),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_edge     (m_edge),
        .m_sof      (m_sof),
        .m_eof      (m_eof),
        .frame_done (frame_done),
        .err_sof    (err_sof)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_out  = 0;
    int n_edge = 0;
    int vpct   = 100;
    int rpct   = 100;
    bit in_flush = 1'b0;
    bit stalled  = 1'b0;
    logic [10:0] held;
    int img [N];
    logic [10:0] exp_q [$];   // {sof, eof, edge, data}
    logic [17:0] in_q  [$];   // {last, sof, thresh, data}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    // Expected output for raster index k, straight from the Sobel definition.
    function automatic logic [10:0] ref_pixel(input int k, input int thr);
        int r, c, gx, gy, mag, d;
        bit e;
        r = k / W;
        c = k % W;
        d = 0;
        e = 1'b0;
        if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
            gx = (px(r-1, c+1) + 2 * px(r, c+1) + px(r+1, c+1))
               - (px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1));
            gy = (px(r+1, c-1) + 2 * px(r+1, c) + px(r+1, c+1))
               - (px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1));
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            d = (mag > 255) ? 255 : mag;
            e = (d >= thr);
        end
        return {k == 0, k == N - 1, e, 8'(d)};
    endfunction

    // Queue the first n_in pixels of img (sof on pixel 0, random thresholds on
    // every other pixel) and the outputs the model says they must produce.
    task automatic queue_frame(input int thr, input int n_in);
        int n_exp;
        for (int i = 0; i < n_in; i++) begin
            in_q.push_back({i == N - 1, i == 0,
                            (i == 0) ? 8'(thr) : 8'($urandom_range(255)), 8'(img[i])});
        end
        n_exp = (n_in == N) ? N : ((n_in > W + 1) ? n_in - W - 1 : 0);
        for (int k = 0; k < n_exp; k++) exp_q.push_back(ref_pixel(k, thr));
    endtask

    task automatic tick();
        logic [10:0] e;
        logic [17:0] item;
        @(negedge clk);
        if (stalled) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_hold", {m_sof, m_eof, m_edge, m_data}, held);
        end
        m_ready = ($urandom_range(99) < rpct);
        if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
            s_valid = 1'b1;
            {s_sof, cfg_thresh, s_data} = in_q[0][16:0];
        end else begin
            s_valid    = 1'b0;
            s_sof      = 1'b0;
            s_data     = 8'($urandom);
            cfg_thresh = 8'($urandom);
        end
        #1;
        if (frame_done) begin
            n_done++;
            in_flush = 1'b0;
            chk("ready_at_done", s_ready, 1);
        end else if (in_flush) begin
            chk("ready_in_flush", s_ready, 0);
        end
        if (err_sof) n_err++;
        if (m_valid && m_ready) begin
            n_out++;
            if (m_edge) n_edge++;
            if (exp_q.size() == 0) begin
                chk("extra_output", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", m_data, e[7:0]);
                chk("out_edge", m_edge, e[8]);
                chk("out_eof", m_eof, e[9]);
                chk("out_sof", m_sof, e[10]);
            end
        end
        stalled = m_valid && !m_ready;
        held    = {m_sof, m_eof, m_edge, m_data};
        if (s_valid && s_ready) begin
            item = in_q.pop_front();
            if (item[17]) in_flush = 1'b1;
        end
    endtask

    task automatic run_until(input int target_done, input int budget);
        int cyc;
        cyc = 0;
        while ((n_done < target_done || exp_q.size() > 0 || in_q.size() > 0) && cyc < budget) begin
            tick();
            cyc++;
        end
        chk("drain_in_time", cyc < budget, 1);
        chk("frame_done_count", n_done, target_done);
    endtask

    task automatic fill_step(input int hi);
        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 3) ? hi : 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) img[i] = $urandom_range(255);
    endtask

    initial begin
        int base_out, base_edge, base_err, cyc;

        // Reset state
        #12;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_edge", m_edge, 0);
        chk("rst_m_sof", m_sof, 0);
        chk("rst_m_eof", m_eof, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_sof", err_sof, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Uniform frame
        for (int i = 0; i < N; i++) img[i] = 100;
        base_out = n_out;
        queue_frame(1, N);
        run_until(1, 400);
        chk("uniform_outputs", n_out - base_out, 25);

        // Vertical step 0 -> 10, threshold 30
        fill_step(10);
        base_out  = n_out;
        base_edge = n_edge;
        queue_frame(30, N);
        run_until(2, 400);
        chk("step_outputs", n_out - base_out, 25);
        chk("step_edges", n_edge - base_edge, 6);

        // Saturating step 0 -> 200
        fill_step(200);
        base_edge = n_edge;
        queue_frame(30, N);
        run_until(3, 400);
        chk("sat_edges", n_edge - base_edge, 6);

        // Backpressure with back-to-back frames
        vpct = 60;
        rpct = 50;
        fill_step(200);
        queue_frame(30, N);
        fill_random();
        queue_frame(300 - 200, N);
        fill_random();
        queue_frame(180, N);
        run_until(6, 3000);
        vpct = 100;
        rpct = 100;

        // Mid-frame s_sof on input index 7, then a clean frame
        base_err = n_err;
        base_out = n_out;
        fill_random();
        queue_frame(50, 7);
        fill_random();
        queue_frame(120, N);
        run_until(7, 600);
        chk("abort_err_pulses", n_err - base_err, 1);
        chk("abort_outputs", n_out - base_out, 26);

        // Reset during FLUSH
        fill_random();
        queue_frame(90, N);
        cyc = 0;
        while (!in_flush && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reach_flush", in_flush, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("flushrst_m_valid", m_valid, 0);
        chk("flushrst_m_data", m_data, 0);
        chk("flushrst_m_eof", m_eof, 0);
        chk("flushrst_s_ready", s_ready, 0);
        chk("flushrst_frame_done", frame_done, 0);
        exp_q.delete();
        in_q.delete();
        in_flush = 1'b0;
        stalled  = 1'b0;
        s_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Threshold latched at s_sof; later cfg_thresh values are noise
        fill_random();
        base_out = n_out;
        queue_frame(250, N);
        run_until(8, 400);
        chk("post_reset_outputs", n_out - base_out, 25);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
